intc_nch: RTL and testbench

INTC_NCH -- requirements
Module: intc_nch

---
 rtl/intc_pkg.sv | 15 +
 rtl/intc_nch_if.sv | 28 ++
 rtl/intc_prio_enc.sv | 19 +
 rtl/intc_nch.sv | 145 ++++++++++++++
 tb/tb_intc_nch.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/intc_pkg.sv
// Shared types for the N-channel interrupt controller.
// FSM state encoding and register-index offsets past the vectors.
package intc_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ASSERT   = 2'd1,
    S_WAIT_REL = 2'd2
  } state_t;

  // MASK and PEND sit just above the NUM_CH vector registers
  localparam int MASK_OFS = 0;
  localparam int PEND_OFS = 1;

endpackage

// File: rtl/intc_nch_if.sv
// Bus, request and processor-handshake bundle for intc_nch.
// master drives requests/bus; slave is the controller.
interface intc_nch_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32
);

  logic [NUM_CH-1:0] irq_in;
  logic              iack;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] wdata;
  logic [ADDR_W-1:0] rdata;
  logic              irq;
  logic [ADDR_W-1:0] isr_addr;
  logic [3:0]        active_id;

  modport master (
    output irq_in, iack, we, addr, wdata,
    input  rdata, irq, isr_addr, active_id
  );

  modport slave (
    input  irq_in, iack, we, addr, wdata,
    output rdata, irq, isr_addr, active_id
  );

endinterface

// File: rtl/intc_prio_enc.sv
// Lowest-index-first priority encoder with valid flag.
// Purely combinational.
module intc_prio_enc #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] req,
  output logic [3:0]        idx,
  output logic              valid
);

  always_comb begin
    idx   = '0;
    valid = |req;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/intc_nch.sv
// N-channel vectored interrupt controller: edge capture,
// pending/mask registers, and irq/iack handshake FSM.
module intc_nch
  import intc_pkg::*;
#(
  parameter int              NUM_CH    = 4,
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0003_0000,
  parameter logic [ADDR_W-1:0] STRIDE    = 32'h0001_0000
) (
  input logic   clk,
  input logic   rst_n,
  intc_nch_if.slave bus
);

  function automatic logic [ADDR_W-1:0] reg_addr(int i);
    return BASE_ADDR + ADDR_W'(i) * STRIDE;
  endfunction

  logic [ADDR_W-1:0] vec [NUM_CH];
  logic [NUM_CH-1:0] mask;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] hist;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] wr_clr;
  logic [NUM_CH-1:0] ack_clr;
  logic [ADDR_W-1:0] rd_val;
  logic [ADDR_W-1:0] gnt_vec;
  logic [ADDR_W-1:0] isr_q;
  logic [ADDR_W-1:0] rdata_q;
  logic [3:0]        id_q;
  logic [3:0]        enc_idx;
  logic              enc_vld;
  logic              hit_mask;
  logic              hit_pend;
  logic              grant;
  state_t            state;
  state_t            state_n;

  assign hit_mask = bus.addr == reg_addr(NUM_CH + MASK_OFS);
  assign hit_pend = bus.addr == reg_addr(NUM_CH + PEND_OFS);
  assign rise     = bus.irq_in & ~hist;
  assign elig     = pend & ~mask;

  intc_prio_enc #(
    .NUM_CH (NUM_CH)
  ) u_enc (
    .req   (elig),
    .idx   (enc_idx),
    .valid (enc_vld)
  );

  always_comb begin
    wr_clr = '0;
    if (bus.we && hit_pend) wr_clr = bus.wdata[NUM_CH-1:0];
  end

  always_comb begin
    ack_clr = '0;
    gnt_vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (state == S_ASSERT && bus.iack && id_q == 4'(i))
        ack_clr[i] = 1'b1;
      if (enc_idx == 4'(i)) gnt_vec = vec[i];
    end
  end

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.addr == reg_addr(i)) rd_val = vec[i];
    end
    if (hit_mask) rd_val = ADDR_W'(mask);
    if (hit_pend) rd_val = ADDR_W'(pend);
  end

  always_comb begin
    state_n = state;
    grant   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enc_vld) begin
          grant   = 1'b1;
          state_n = S_ASSERT;
        end
      end
      S_ASSERT: begin
        if (bus.iack) state_n = S_WAIT_REL;
      end
      S_WAIT_REL: begin
        if (!bus.iack) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // a new edge beats any clear landing on the same bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0;
      pend <= '0;
    end else begin
      hist <= bus.irq_in;
      pend <= (pend & ~(wr_clr | ack_clr)) | rise;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '0;
      for (int i = 0; i < NUM_CH; i++) vec[i] <= reg_addr(i);
    end else if (bus.we) begin
      if (hit_mask) mask <= bus.wdata[NUM_CH-1:0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.addr == reg_addr(i)) vec[i] <= bus.wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q    <= '0;
      isr_q   <= '0;
      rdata_q <= '0;
    end else begin
      rdata_q <= rd_val;
      if (grant) begin
        id_q  <= enc_idx;
        isr_q <= gnt_vec;
      end
    end
  end

  assign bus.irq       = state == S_ASSERT;
  assign bus.isr_addr  = isr_q;
  assign bus.active_id = id_q;
  assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_intc_nch.sv
// Directed and randomized bench for intc_nch against
// a behavioural model of the controller rules.
module tb_intc_nch;

  localparam logic [31:0] BASE   = 32'h0003_0000;
  localparam logic [31:0] STRIDE = 32'h0001_0000;
  localparam logic [31:0] A_MASK = BASE + 4 * STRIDE;
  localparam logic [31:0] A_PEND = BASE + 5 * STRIDE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  intc_nch_if #(.NUM_CH(4), .ADDR_W(32)) bus ();

  intc_nch #(
    .NUM_CH    (4),
    .ADDR_W    (32),
    .BASE_ADDR (BASE),
    .STRIDE    (STRIDE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_vec [4];
  logic [3:0]  m_mask, m_pend, m_prev, m_id;
  logic [31:0] m_isr, m_rd;
  bit          m_busy, m_wait;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if (a == BASE + i * STRIDE) return m_vec[i];
    if (a == A_MASK) return {28'd0, m_mask};
    if (a == A_PEND) return {28'd0, m_pend};
    return 32'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_vec[i] = BASE + i * STRIDE;
    m_mask = 0; m_pend = 0; m_prev = 0; m_id = 0;
    m_isr = 0; m_rd = 0; m_busy = 0; m_wait = 0;
  endtask

  task automatic model_step();
    logic [31:0] rd;
    logic [3:0]  rise, clr, el;
    rd   = m_read(bus.addr);
    rise = bus.irq_in & ~m_prev;
    clr  = 0;
    if (bus.we && bus.addr == A_PEND) clr = bus.wdata[3:0];
    if (m_busy && bus.iack) clr[m_id] = 1'b1;
    el = m_pend & ~m_mask;
    if (m_busy) begin
      if (bus.iack) begin m_busy = 0; m_wait = 1; end
    end else if (m_wait) begin
      if (!bus.iack) m_wait = 0;
    end else if (el != 0) begin
      for (int i = 3; i >= 0; i--)
        if (el[i]) m_id = 4'(i);
      m_isr  = m_vec[m_id];
      m_busy = 1;
    end
    if (bus.we) begin
      for (int i = 0; i < 4; i++)
        if (bus.addr == BASE + i * STRIDE) m_vec[i] = bus.wdata;
      if (bus.addr == A_MASK) m_mask = bus.wdata[3:0];
    end
    m_pend = (m_pend & ~clr) | rise;
    m_prev = bus.irq_in;
    m_rd   = rd;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("irq", {31'd0, bus.irq}, {31'd0, m_busy});
    chk("isr_addr", bus.isr_addr, m_isr);
    chk("active_id", {28'd0, bus.active_id}, {28'd0, m_id});
    chk("rdata", bus.rdata, m_rd);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.irq_in = 0; bus.iack = 0; bus.we = 0;
    bus.addr = 0; bus.wdata = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_irq", {31'd0, bus.irq}, 32'd0);
    chk("rst_isr", bus.isr_addr, 32'd0);
    chk("rst_id", {28'd0, bus.active_id}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic wr(logic [31:0] a, logic [31:0] d);
    bus.addr = a; bus.wdata = d; bus.we = 1;
    step();
    bus.we = 0;
  endtask

  task automatic rd(string tag, logic [31:0] a,
                    logic [31:0] exp);
    bus.addr = a; bus.we = 0;
    step();
    chk(tag, bus.rdata, exp);
  endtask

  task automatic pulse(logic [3:0] v);
    bus.irq_in = v;
    step();
    bus.irq_in = 0;
  endtask

  task automatic ack();
    bus.iack = 1;
    step();
    bus.iack = 0;
    step();
  endtask

  initial begin
    do_reset();

    rd("vec3", BASE + 3 * STRIDE, 32'h0006_0000);
    rd("mask0", A_MASK, 32'd0);
    rd("pend0", A_PEND, 32'd0);

    pulse(4'b1000);
    chk("t3_early", {31'd0, bus.irq}, 32'd0);
    step();
    chk("t3_irq", {31'd0, bus.irq}, 32'd1);
    chk("t3_isr", bus.isr_addr, 32'h0006_0000);
    chk("t3_id", {28'd0, bus.active_id}, 32'd3);
    bus.iack = 1;
    step();
    chk("t3_drop", {31'd0, bus.irq}, 32'd0);
    bus.iack = 0;
    step();
    rd("t3_pend", A_PEND, 32'd0);

    wr(BASE + 2 * STRIDE, 32'h0000_1234);
    pulse(4'b0100);
    step();
    chk("t4_isr", bus.isr_addr, 32'h0000_1234);
    ack();
    wr(BASE + 2 * STRIDE, 32'h0005_0000);

    pulse(4'b0101);
    step();
    chk("t5_id0", {28'd0, bus.active_id}, 32'd0);
    chk("t5_isr0", bus.isr_addr, 32'h0003_0000);
    ack();
    chk("t5_gap", {31'd0, bus.irq}, 32'd0);
    step();
    chk("t5_irq2", {31'd0, bus.irq}, 32'd1);
    chk("t5_id2", {28'd0, bus.active_id}, 32'd2);
    chk("t5_isr2", bus.isr_addr, 32'h0005_0000);
    ack();

    wr(A_MASK, 32'h2);
    pulse(4'b0010);
    repeat (3) step();
    chk("t6_masked", {31'd0, bus.irq}, 32'd0);
    rd("t6_pend", A_PEND, 32'h2);
    wr(A_MASK, 32'h0);
    step();
    chk("t6_irq", {31'd0, bus.irq}, 32'd1);
    chk("t6_id", {28'd0, bus.active_id}, 32'd1);

    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t7_irq", {31'd0, bus.irq}, 32'd0);
    do_reset();
    rd("t7_pend", A_PEND, 32'd0);
    repeat (5) step();
    chk("t7_quiet", {31'd0, bus.irq}, 32'd0);

    for (int c = 0; c < 3000; c++) begin
      int r, k;
      if (c == 1500) do_reset();
      r = $urandom % 4;
      if (r == 0) bus.irq_in = 4'($urandom);
      else if (r == 1) bus.irq_in = 0;
      bus.iack = ($urandom % 3) == 0;
      bus.we   = ($urandom % 6) == 0;
      k = $urandom % 8;
      if (k < 7) bus.addr = BASE + k * STRIDE;
      else       bus.addr = $urandom;
      bus.wdata = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
